// File: rtl/hazard_control_unit_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs, debug halt, and pipeline control outputs.
// master = pipeline/debug side, slave = hazard_control_unit.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_if_id_i;
  logic [4:0]       rs2_if_id_i;
  logic             rs1_used_if_id_en;
  logic             rs2_used_if_id_en;
  logic [4:0]       rd_id_ex_i;
  logic             mem_read_id_ex_en;
  logic             branch_taken_ex_en;
  logic             mem_access_ex_mem_en;
  logic             mem_ready_i;
  logic             halt_req_i;
  logic             cnt_clr_i;
  logic             pc_write_en_o;
  logic             if_id_write_en_o;
  logic             if_id_flush_en_o;
  logic             id_ex_flush_en_o;
  logic             pipe_freeze_en_o;
  logic             halted_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output rs1_if_id_i, rs2_if_id_i, rs1_used_if_id_en, rs2_used_if_id_en,
           rd_id_ex_i, mem_read_id_ex_en, branch_taken_ex_en,
           mem_access_ex_mem_en, mem_ready_i, halt_req_i, cnt_clr_i,
    input  pc_write_en_o, if_id_write_en_o, if_id_flush_en_o, id_ex_flush_en_o,
           pipe_freeze_en_o, halted_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  rs1_if_id_i, rs2_if_id_i, rs1_used_if_id_en, rs2_used_if_id_en,
           rd_id_ex_i, mem_read_id_ex_en, branch_taken_ex_en,
           mem_access_ex_mem_en, mem_ready_i, halt_req_i, cnt_clr_i,
    output pc_write_en_o, if_id_write_en_o, if_id_flush_en_o, id_ex_flush_en_o,
           pipe_freeze_en_o, halted_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall, branch flush, memory-wait freeze and debug halt/drain control for the 5-stage core.
// Control outputs are same-cycle combinational; state, counters and status flags update on the rising edge.
module hazard_control_unit #(
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  hazard_control_unit_if.slave hcu
);
  localparam int DW = (DRAIN_CYCLES   > 1) ? $clog2(DRAIN_CYCLES + 1)   : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [WW-1:0]    wait_q;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic memwait, branch, loaduse;
  logic stall_evt, flush_evt;
  logic pc_we, if_id_we, if_id_flush, id_ex_flush, freeze;

  assign memwait = hcu.mem_access_ex_mem_en && !hcu.mem_ready_i;
  assign branch  = hcu.branch_taken_ex_en;
  assign loaduse = hcu.mem_read_id_ex_en && (hcu.rd_id_ex_i != 5'd0) &&
                   ((hcu.rs1_used_if_id_en && (hcu.rs1_if_id_i == hcu.rd_id_ex_i)) ||
                    (hcu.rs2_used_if_id_en && (hcu.rs2_if_id_i == hcu.rd_id_ex_i)));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    freeze      = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    case (state_q)
      HALTED: begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
        freeze   = 1'b1;
        if (!hcu.halt_req_i) state_d = RUN;
      end
      default: begin
        if (memwait) begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          freeze    = 1'b1;
          stall_evt = 1'b1;
        end else if (branch) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (loaduse) begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
          stall_evt   = 1'b1;
        end else if (state_q == DRAIN) begin
          // Bubble into IF/ID while the instruction in ID moves on; PC holds so nothing is lost.
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
        end

        if (state_q == RUN) begin
          if (hcu.halt_req_i && !memwait) begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end else if (!hcu.halt_req_i) begin
          state_d = RUN;
        end else if (!memwait && (branch || !loaduse)) begin
          // Only cycles that actually retire a slot count toward the drain.
          if (drain_q == DW'(1)) begin
            state_d = HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else if (memwait) begin
      if (wait_q != WW'(TIMEOUT_CYCLES)) wait_q <= wait_q + WW'(1);
      if (wait_q == WW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (hcu.cnt_clr_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hcu.pc_write_en_o    = pc_we;
  assign hcu.if_id_write_en_o = if_id_we;
  assign hcu.if_id_flush_en_o = if_id_flush;
  assign hcu.id_ex_flush_en_o = id_ex_flush;
  assign hcu.pipe_freeze_en_o = freeze;
  assign hcu.halted_o         = (state_q == HALTED);
  assign hcu.mem_timeout_o    = timeout_q;
  assign hcu.stall_cnt_o      = stall_q;
  assign hcu.flush_cnt_o      = flush_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with DRAIN_CYCLES=4, TIMEOUT_CYCLES=4, CNT_W=4.
module tb_hazard_control_unit;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int total = 0;
  int bad = 0;

  hazard_control_unit_if #(.CNT_W(4)) hif();

  hazard_control_unit #(.DRAIN_CYCLES(4), .TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .hcu   (hif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.rs1_if_id_i = 5'd0;
    hif.rs2_if_id_i = 5'd0;
    hif.rs1_used_if_id_en = 1'b0;
    hif.rs2_used_if_id_en = 1'b0;
    hif.rd_id_ex_i = 5'd0;
    hif.mem_read_id_ex_en = 1'b0;
    hif.branch_taken_ex_en = 1'b0;
    hif.mem_access_ex_mem_en = 1'b0;
    hif.mem_ready_i = 1'b1;
    hif.halt_req_i = 1'b0;
    hif.cnt_clr_i = 1'b0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd, input logic [4:0] rs1, input logic used1);
    hif.mem_read_id_ex_en = 1'b1;
    hif.rd_id_ex_i = rd;
    hif.rs1_if_id_i = rs1;
    hif.rs1_used_if_id_en = used1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    #2;
    total++; if (hif.halted_o !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", hif.halted_o); end
    total++; if (hif.mem_timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", hif.mem_timeout_o); end
    total++; if (hif.stall_cnt_o !== 4'd0 || hif.flush_cnt_o !== 4'd0) begin bad++; $display("FAIL reset_cnts stall=%0d flush=%0d exp=0/0", hif.stall_cnt_o, hif.flush_cnt_o); end
    total++; if ({hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o, hif.pipe_freeze_en_o} !== 5'b11000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=11000", {hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o, hif.pipe_freeze_en_o});
    end
  endtask

  task automatic test_load_use();
    idle();
    set_loaduse(5'd5, 5'd5, 1'b1);
    #2;
    total++; if ({hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o, hif.pipe_freeze_en_o} !== 5'b00010) begin
      bad++; $display("FAIL loaduse_ctrl got=%b exp=00010", {hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o, hif.pipe_freeze_en_o});
    end
    tick();
    idle();
    #2;
    total++; if (hif.stall_cnt_o !== 4'd1) begin bad++; $display("FAIL loaduse_cnt got=%0d exp=1", hif.stall_cnt_o); end
    total++; if (hif.pc_write_en_o !== 1'b1 || hif.id_ex_flush_en_o !== 1'b0) begin bad++; $display("FAIL loaduse_one_bubble pc_we=%b id_ex_flush=%b exp=1/0", hif.pc_write_en_o, hif.id_ex_flush_en_o); end
    set_loaduse(5'd0, 5'd0, 1'b1);
    #2;
    total++; if (hif.pc_write_en_o !== 1'b1 || hif.id_ex_flush_en_o !== 1'b0) begin bad++; $display("FAIL loaduse_rd0 pc_we=%b id_ex_flush=%b exp=1/0", hif.pc_write_en_o, hif.id_ex_flush_en_o); end
    tick();
    set_loaduse(5'd5, 5'd5, 1'b0);
    #2;
    total++; if (hif.pc_write_en_o !== 1'b1 || hif.if_id_write_en_o !== 1'b1) begin bad++; $display("FAIL loaduse_unused pc_we=%b if_id_we=%b exp=1/1", hif.pc_write_en_o, hif.if_id_write_en_o); end
    tick();
    idle();
    hif.mem_read_id_ex_en = 1'b1;
    hif.rd_id_ex_i = 5'd7;
    hif.rs2_if_id_i = 5'd7;
    hif.rs2_used_if_id_en = 1'b1;
    #2;
    total++; if (hif.pc_write_en_o !== 1'b0 || hif.id_ex_flush_en_o !== 1'b1) begin bad++; $display("FAIL loaduse_rs2 pc_we=%b id_ex_flush=%b exp=0/1", hif.pc_write_en_o, hif.id_ex_flush_en_o); end
    tick();
    idle();
    #2;
    total++; if (hif.stall_cnt_o !== 4'd2) begin bad++; $display("FAIL loaduse_cnt_total got=%0d exp=2", hif.stall_cnt_o); end
  endtask

  task automatic test_priority();
    idle();
    hif.cnt_clr_i = 1'b1;
    tick();
    idle();
    set_loaduse(5'd3, 5'd3, 1'b1);
    hif.branch_taken_ex_en = 1'b1;
    #2;
    total++; if ({hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o, hif.pipe_freeze_en_o} !== 5'b11110) begin
      bad++; $display("FAIL branch_over_loaduse got=%b exp=11110", {hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o, hif.pipe_freeze_en_o});
    end
    tick();
    #1;
    total++; if (hif.flush_cnt_o !== 4'd1 || hif.stall_cnt_o !== 4'd0) begin bad++; $display("FAIL branch_cnts flush=%0d stall=%0d exp=1/0", hif.flush_cnt_o, hif.stall_cnt_o); end
    hif.mem_access_ex_mem_en = 1'b1;
    hif.mem_ready_i = 1'b0;
    #2;
    total++; if ({hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o, hif.pipe_freeze_en_o} !== 5'b00001) begin
      bad++; $display("FAIL memwait_over_all got=%b exp=00001", {hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o, hif.pipe_freeze_en_o});
    end
    tick();
    idle();
    #1;
    total++; if (hif.flush_cnt_o !== 4'd1 || hif.stall_cnt_o !== 4'd1) begin bad++; $display("FAIL memwait_cnts flush=%0d stall=%0d exp=1/1", hif.flush_cnt_o, hif.stall_cnt_o); end
  endtask

  task automatic test_timeout();
    idle();
    tick();
    hif.mem_access_ex_mem_en = 1'b1;
    hif.mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (hif.pipe_freeze_en_o !== 1'b1 || hif.pc_write_en_o !== 1'b0) begin bad++; $display("FAIL wait3_freeze cyc=%0d freeze=%b pc_we=%b exp=1/0", i, hif.pipe_freeze_en_o, hif.pc_write_en_o); end
      tick();
    end
    hif.mem_ready_i = 1'b1;
    #2;
    total++; if (hif.pipe_freeze_en_o !== 1'b0 || hif.mem_timeout_o !== 1'b0) begin bad++; $display("FAIL wait3_release freeze=%b timeout=%b exp=0/0", hif.pipe_freeze_en_o, hif.mem_timeout_o); end
    tick();
    hif.mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) begin
        total++; if (hif.mem_timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", hif.mem_timeout_o); end
      end
    end
    total++; if (hif.mem_timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_rise got=%b exp=1", hif.mem_timeout_o); end
    hif.mem_ready_i = 1'b1;
    tick();
    hif.cnt_clr_i = 1'b1;
    tick();
    hif.cnt_clr_i = 1'b0;
    #1;
    total++; if (hif.mem_timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", hif.mem_timeout_o); end
    idle();
  endtask

  task automatic test_halt();
    idle();
    tick();
    hif.halt_req_i = 1'b1;
    #2;
    total++; if (hif.pc_write_en_o !== 1'b1) begin bad++; $display("FAIL halt_run_cycle pc_we=%b exp=1", hif.pc_write_en_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (hif.pc_write_en_o !== 1'b0 || hif.if_id_flush_en_o !== 1'b1 || hif.halted_o !== 1'b0) begin
        bad++; $display("FAIL drain_cyc%0d pc_we=%b if_id_flush=%b halted=%b exp=0/1/0", i, hif.pc_write_en_o, hif.if_id_flush_en_o, hif.halted_o);
      end
      tick();
    end
    #1;
    total++; if ({hif.halted_o, hif.pipe_freeze_en_o, hif.pc_write_en_o, hif.if_id_write_en_o} !== 4'b1100) begin
      bad++; $display("FAIL halted_state got=%b exp=1100", {hif.halted_o, hif.pipe_freeze_en_o, hif.pc_write_en_o, hif.if_id_write_en_o});
    end
    tick();
    hif.halt_req_i = 1'b0;
    tick();
    #1;
    total++; if (hif.halted_o !== 1'b0 || hif.pc_write_en_o !== 1'b1 || hif.pipe_freeze_en_o !== 1'b0) begin
      bad++; $display("FAIL halt_release halted=%b pc_we=%b freeze=%b exp=0/1/0", hif.halted_o, hif.pc_write_en_o, hif.pipe_freeze_en_o);
    end
  endtask

  task automatic test_drain_loaduse();
    idle();
    hif.halt_req_i = 1'b1;
    tick();
    tick();
    set_loaduse(5'd9, 5'd9, 1'b1);
    #2;
    total++; if ({hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o} !== 4'b0001) begin
      bad++; $display("FAIL drain_loaduse_ctrl got=%b exp=0001", {hif.pc_write_en_o, hif.if_id_write_en_o, hif.if_id_flush_en_o, hif.id_ex_flush_en_o});
    end
    tick();
    idle();
    hif.halt_req_i = 1'b1;
    tick();
    tick();
    total++; if (hif.halted_o !== 1'b0) begin bad++; $display("FAIL drain_extend_early got=%b exp=0", hif.halted_o); end
    tick();
    total++; if (hif.halted_o !== 1'b1) begin bad++; $display("FAIL drain_extend_done got=%b exp=1", hif.halted_o); end
    hif.halt_req_i = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    idle();
    hif.cnt_clr_i = 1'b1;
    tick();
    idle();
    set_loaduse(5'd4, 5'd4, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    total++; if (hif.stall_cnt_o !== 4'd15) begin bad++; $display("FAIL stall_saturate got=%0d exp=15", hif.stall_cnt_o); end
    hif.cnt_clr_i = 1'b1;
    tick();
    total++; if (hif.stall_cnt_o !== 4'd0) begin bad++; $display("FAIL clr_priority got=%0d exp=0", hif.stall_cnt_o); end
    idle();
  endtask

  task automatic test_reset_mid_drain();
    idle();
    hif.cnt_clr_i = 1'b1;
    tick();
    idle();
    set_loaduse(5'd6, 5'd6, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    idle();
    hif.branch_taken_ex_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    total++; if (hif.stall_cnt_o !== 4'd7 || hif.flush_cnt_o !== 4'd7) begin bad++; $display("FAIL pre_reset_cnts stall=%0d flush=%0d exp=7/7", hif.stall_cnt_o, hif.flush_cnt_o); end
    idle();
    hif.halt_req_i = 1'b1;
    tick();
    tick();
    total++; if (hif.pc_write_en_o !== 1'b0) begin bad++; $display("FAIL pre_reset_drain pc_we=%b exp=0", hif.pc_write_en_o); end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    hif.halt_req_i = 1'b0;
    #2;
    total++; if (hif.stall_cnt_o !== 4'd0 || hif.flush_cnt_o !== 4'd0) begin bad++; $display("FAIL mid_reset_cnts stall=%0d flush=%0d exp=0/0", hif.stall_cnt_o, hif.flush_cnt_o); end
    total++; if (hif.mem_timeout_o !== 1'b0 || hif.halted_o !== 1'b0) begin bad++; $display("FAIL mid_reset_flags timeout=%b halted=%b exp=0/0", hif.mem_timeout_o, hif.halted_o); end
    total++; if (hif.pc_write_en_o !== 1'b1 || hif.if_id_flush_en_o !== 1'b0) begin bad++; $display("FAIL mid_reset_run pc_we=%b if_id_flush=%b exp=1/0", hif.pc_write_en_o, hif.if_id_flush_en_o); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_timeout();
    test_halt();
    test_drain_loaduse();
    test_saturation();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
